pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Parametrised successor of the combinational PC incrementer.
- Holds the program counter in a register and advances it by STEP each cycle.
- Supports stall, PC-relative branch, absolute jump and halt/resume.
- A one-deep pending-redirect buffer ensures redirects raised during stall/halt are never lost.
- Sits between the fetch stage (drives instruction memory address) and branch/jump resolution logic.

Parameters:
- ADDR_W, 16, width of PC and all address ports.
- OFF_W, 8, width of signed branch offset (ADDR_W >= OFF_W).
- STEP, 1, sequential increment in address units.
- RESET_ADDR, 0, PC value loaded by reset.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- stall_i  in  1  hold PC this cycle.
- halt_i  in  1  request entry to HALT (sampled in RUN only).
- resume_i  in  1  leave HALT.
- branch_i  in  1  take PC-relative branch.
- offset_i  in  OFF_W  signed branch offset.
- jump_i  in  1  take absolute jump.
- target_i  in  ADDR_W  absolute jump target.
- pc_o  out  ADDR_W  current PC (registered).
- pc_next_o  out  ADDR_W  pc_o+STEP mod 2^ADDR_W (combinational; return address).
- pc_valid_o  out  1  pc_o is a fetchable address this cycle.
- pend_o  out  1  pending redirect held.
- wrap_o  out  1  one-cycle pulse: last sequential advance wrapped past all-ones.

Behaviour:
- Reset (async assert, sync deassert by clk):
  - pc_o=RESET_ADDR, state=BOOT, pc_valid_o=0, pend_o=0, wrap_o=0, pending target=0.
- States:
  - BOOT: lasts exactly one cycle after reset release, ignores all inputs; -> RUN. pc_valid_o=0.
  - RUN: pc_valid_o=1.
  - HALT: pc_valid_o=0.
- Redirect target computation:
  - Branch target = pc_o + STEP + sext(offset_i), mod 2^ADDR_W.
  - Jump target = target_i.
  - jump_i and branch_i together: jump wins.
- "Advance cycle": state==RUN and stall_i==0 and halt_i==0.
- Next PC in an advance cycle, priority order:
  1. Live redirect (jump/branch this cycle). Pending buffer cleared; live wins over pending.
  2. Pending target, then pend_o cleared.
  3. pc_o+STEP.
- Non-advance cycle in RUN (stall or halt request), or cycle in HALT:
  - PC holds.
  - Any live redirect is captured into the pending buffer, pend_o=1 next cycle.
  - A newer redirect overwrites an older pending one (latest wins).
- halt_i in RUN:
  - Goes to HALT next edge; PC holds that cycle.
  - halt_i and redirect together: redirect captured as pending.
- resume_i in HALT:
  - Goes to RUN next edge; PC still holds on that edge.
  - The first RUN advance cycle applies the pending target, if any.
  - halt_i ignored in HALT; resume_i ignored outside HALT.
- wrap_o: 1 for one cycle after a sequential (non-redirect) advance where pc_o+STEP overflowed ADDR_W; 0 otherwise. Redirect targets never set wrap_o.
- Reset mid-operation: immediately restores the reset values above; pending redirect discarded.
- Latency: redirect presented in an advance cycle appears on pc_o after the next rising edge (1 cycle).

Test Plan:
- Release reset with RESET_ADDR=0, STEP=1, no other inputs -> pc_o sequence 0 (BOOT, valid=0), 0 (valid=1), 1, 2, 3.
- At pc_o=5, branch_i=1, offset_i=8'hFC -> next pc_o=2 (5+1-4). Same cycle with jump_i=1, target_i=16'h0100 -> next pc_o=0x0100.
- At pc_o=10, stall_i=1 for 3 cycles; jump to 0x0040 in stall cycle 1 and branch offset +2 in stall cycle 2:
  - pc_o holds 10; pend_o=1 from stall cycle 2.
  - Stall release -> pc_o=13 (branch overwrote jump; target 10+1+2); pend_o=0.
- halt_i at pc_o=7, jump to 0x0020 during HALT, resume_i two cycles later -> pc_o holds 7 with valid=0 through HALT and the resume edge, then 0x0020 with valid=1.
- Load pc_o=16'hFFFF via jump, then one advance -> pc_o=0, wrap_o=1 for exactly one cycle. Jump to 0 from 16'hFFFF instead -> wrap_o stays 0.
- Assert rst_n=0 mid-stall with pend_o=1 -> pc_o=RESET_ADDR and pend_o=0 immediately without a clock edge; after release, BOOT sequence repeats.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: registered program counter with stall, PC-relative branch,
// absolute jump, halt/resume and a one-deep pending-redirect buffer.
//
// Ports:
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   stall_i      hold PC this cycle (live redirect is buffered)
//   halt_i       enter HALT (sampled in RUN only)
//   resume_i     leave HALT
//   branch_i     take branch to pc_o + STEP + sext(offset_i)
//   offset_i     signed branch offset
//   jump_i       take absolute jump to target_i (wins over branch_i)
//   target_i     absolute jump target
//   pc_o         current PC (registered)
//   pc_next_o    pc_o + STEP, combinational (return address)
//   pc_valid_o   pc_o is fetchable (RUN state)
//   pend_o       a redirect is held in the pending buffer
//   wrap_o       one-cycle pulse after a sequential advance that wrapped
module pc_sequencer #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned OFF_W  = 8,
    parameter int unsigned STEP   = 1,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_i,
    input  logic              halt_i,
    input  logic              resume_i,
    input  logic              branch_i,
    input  logic [OFF_W-1:0]  offset_i,
    input  logic              jump_i,
    input  logic [ADDR_W-1:0] target_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] pc_next_o,
    output logic              pc_valid_o,
    output logic              pend_o,
    output logic              wrap_o
);

    localparam int unsigned SUM_W = ADDR_W + 1;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] tgt_q, tgt_d;
    logic              wrap_q, wrap_d;
    logic              valid_q;

    logic [SUM_W-1:0]  seq_sum;
    logic [ADDR_W-1:0] seq_pc;
    logic              seq_carry;
    logic [ADDR_W-1:0] branch_tgt;
    logic              live;
    logic [ADDR_W-1:0] live_tgt;

    // Sequential successor with carry-out to detect wrap past all-ones.
    assign seq_sum   = SUM_W'(pc_q) + SUM_W'(STEP);
    assign seq_pc    = seq_sum[ADDR_W-1:0];
    assign seq_carry = seq_sum[ADDR_W];

    // Live redirect target; jump has priority over branch.
    assign branch_tgt = seq_pc + ADDR_W'($signed(offset_i));
    assign live       = jump_i | branch_i;
    assign live_tgt   = jump_i ? target_i : branch_tgt;

    assign pc_o       = pc_q;
    assign pc_next_o  = seq_pc;
    assign pc_valid_o = valid_q;
    assign pend_o     = pend_q;
    assign wrap_o     = wrap_q;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_ADDR;
            pend_q  <= 1'b0;
            tgt_q   <= '0;
            wrap_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            tgt_q   <= tgt_d;
            wrap_q  <= wrap_d;
            valid_q <= (state_d == ST_RUN);
        end
    end

    // Next-state and next-PC selection.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        tgt_d   = tgt_q;
        wrap_d  = 1'b0;

        unique case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!stall_i && !halt_i) begin
                    if (live) begin
                        pc_d   = live_tgt;
                        pend_d = 1'b0;
                    end else if (pend_q) begin
                        pc_d   = tgt_q;
                        pend_d = 1'b0;
                    end else begin
                        pc_d   = seq_pc;
                        wrap_d = seq_carry;
                    end
                end else begin
                    // PC holds; newest redirect replaces any older pending one.
                    if (live) begin
                        pend_d = 1'b1;
                        tgt_d  = live_tgt;
                    end
                    if (halt_i) begin
                        state_d = ST_HALT;
                    end
                end
            end
            ST_HALT: begin
                if (live) begin
                    pend_d = 1'b1;
                    tgt_d  = live_tgt;
                end
                if (resume_i) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: directed scenarios followed by random stimulus,
// all checked against a behavioural model of the PC sequencer.
module tb_pc_sequencer;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned OFF_W  = 8;
    localparam int unsigned STEP   = 1;
    localparam int          MASK   = (1 << ADDR_W) - 1;
    localparam int          RST_PC = 0;

    logic              clk;
    logic              rst_n;
    logic              stall_i, halt_i, resume_i, branch_i, jump_i;
    logic [OFF_W-1:0]  offset_i;
    logic [ADDR_W-1:0] target_i;
    logic [ADDR_W-1:0] pc_o, pc_next_o;
    logic              pc_valid_o, pend_o, wrap_o;

    int checks = 0;
    int errors = 0;

    // Behavioural model: mode 0=boot, 1=run, 2=halt.
    int m_mode;
    int m_pc;
    bit m_pend;
    int m_tgt;
    bit m_wrap;

    pc_sequencer #(
        .ADDR_W(ADDR_W), .OFF_W(OFF_W), .STEP(STEP), .RESET_ADDR(16'(RST_PC))
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .stall_i(stall_i), .halt_i(halt_i), .resume_i(resume_i),
        .branch_i(branch_i), .offset_i(offset_i),
        .jump_i(jump_i), .target_i(target_i),
        .pc_o(pc_o), .pc_next_o(pc_next_o), .pc_valid_o(pc_valid_o),
        .pend_o(pend_o), .wrap_o(wrap_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc"},    32'(pc_o),       32'(m_pc));
        check({tag, ".valid"}, 32'(pc_valid_o), 32'(m_mode == 1));
        check({tag, ".pend"},  32'(pend_o),     32'(m_pend));
        check({tag, ".wrap"},  32'(wrap_o),     32'(m_wrap));
        check({tag, ".next"},  32'(pc_next_o),  32'((m_pc + STEP) & MASK));
    endtask

    task automatic model_reset();
        m_mode = 0; m_pc = RST_PC; m_pend = 0; m_tgt = 0; m_wrap = 0;
    endtask

    // One clock with the given inputs; model advanced, outputs checked after the edge.
    task automatic cycle(input bit st, input bit hl, input bit rs, input bit br,
                         input logic [OFF_W-1:0] off, input bit jp,
                         input logic [ADDR_W-1:0] tg, input string tag);
        bit live;
        int ltgt;
        stall_i = st; halt_i = hl; resume_i = rs; branch_i = br;
        offset_i = off; jump_i = jp; target_i = tg;
        live = jp || br;
        ltgt = jp ? int'(tg) : ((m_pc + STEP + int'($signed(off))) & MASK);
        m_wrap = 0;
        if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1 && !st && !hl) begin
            if (live) begin
                m_pc = ltgt; m_pend = 0;
            end else if (m_pend) begin
                m_pc = m_tgt; m_pend = 0;
            end else begin
                m_wrap = (m_pc + STEP) > MASK;
                m_pc = (m_pc + STEP) & MASK;
            end
        end else begin
            if (live) begin
                m_pend = 1; m_tgt = ltgt;
            end
            if (m_mode == 1 && hl) m_mode = 2;
            else if (m_mode == 2 && rs) m_mode = 1;
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        cycle(0, 0, 0, 0, '0, 0, '0, tag);
    endtask

    task automatic jump_to(input logic [ADDR_W-1:0] t, input string tag);
        cycle(0, 0, 0, 0, '0, 1, t, tag);
    endtask

    // Asynchronous reset assertion, checked before any clock edge, then released.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #2;
        model_reset();
        check_all(tag);
        check({tag, ".rpc"}, 32'(pc_o), 32'(RST_PC));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        stall_i = 0; halt_i = 0; resume_i = 0; branch_i = 0; jump_i = 0;
        offset_i = '0; target_i = '0;
        rst_n = 1'b1;
        model_reset();
        #3;
        do_reset("rst0");

        // Boot sequence: 0 (valid), 1, 2, 3
        idle("boot0"); check("boot0.v", 32'(pc_valid_o), 32'd1); check("boot0.pc", 32'(pc_o), 32'd0);
        idle("seq1");  check("seq1.pc", 32'(pc_o), 32'd1);
        idle("seq2");
        idle("seq3");  check("seq3.pc", 32'(pc_o), 32'd3);
        idle("seq4");
        idle("seq5");  check("seq5.pc", 32'(pc_o), 32'd5);

        // Branch -4 from 5 -> 2; jump+branch -> jump wins
        cycle(0, 0, 0, 1, 8'hFC, 0, '0, "br");     check("br.pc", 32'(pc_o), 32'd2);
        jump_to(16'd5, "j5");
        cycle(0, 0, 0, 1, 8'hFC, 1, 16'h0100, "jb"); check("jb.pc", 32'(pc_o), 32'h100);

        // Stall with overwritten pending redirect
        jump_to(16'd10, "j10");
        cycle(1, 0, 0, 0, '0, 1, 16'h0040, "st1");
        cycle(1, 0, 0, 1, 8'd2, 0, '0, "st2");    check("st2.pend", 32'(pend_o), 32'd1);
        cycle(1, 0, 0, 0, '0, 0, '0, "st3");      check("st3.pc", 32'(pc_o), 32'd10);
        idle("strel"); check("strel.pc", 32'(pc_o), 32'd13); check("strel.pend", 32'(pend_o), 32'd0);

        // Halt, redirect during halt, resume
        jump_to(16'd7, "j7");
        cycle(0, 1, 0, 0, '0, 0, '0, "h0");
        cycle(0, 0, 0, 0, '0, 1, 16'h0020, "h1");
        idle("h2");
        cycle(0, 0, 1, 0, '0, 0, '0, "hres");     check("hres.pc", 32'(pc_o), 32'd7);
        check("hres.v", 32'(pc_valid_o), 32'd1);
        idle("hrun"); check("hrun.pc", 32'(pc_o), 32'h20);

        // Wrap pulse on sequential overflow only
        jump_to(16'hFFFF, "jff");
        idle("wr");   check("wr.wrap", 32'(wrap_o), 32'd1); check("wr.pc", 32'(pc_o), 32'd0);
        idle("wr2");  check("wr2.wrap", 32'(wrap_o), 32'd0);
        jump_to(16'hFFFF, "jff2");
        jump_to(16'h0000, "j0");  check("j0.wrap", 32'(wrap_o), 32'd0);

        // Reset mid-stall with pending redirect
        cycle(1, 0, 0, 0, '0, 1, 16'h0033, "pst");  check("pst.pend", 32'(pend_o), 32'd1);
        do_reset("rst1");
        check("rst1.pend", 32'(pend_o), 32'd0);
        idle("boot1"); idle("boot1b"); check("boot1b.pc", 32'(pc_o), 32'd1);

        // Randomized stimulus
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset("rrst");
            end else begin
                cycle($urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0,
                      $urandom_range(0, 4) == 0, $urandom_range(0, 6) == 0,
                      8'($urandom), $urandom_range(0, 9) == 0,
                      ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom), "rnd");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
